// File: rtl/modinv_helper_sub.sv
// modinv_helper_sub: multi-word subtractor S = A - B for the modular invertor.
// Walks OPERAND_NUM_WORDS 32-bit words LSW first, then writes one sign-extension
// word, and registers the final borrow as neg (A < B).
// Optional build macro: MODINV_HELPER_SUB_ZERO_FLAG_EN adds output 'zero'
// (set when every result word is zero, i.e. A == B).
module modinv_helper_sub #(
   parameter int OPERAND_NUM_WORDS = 8,
   parameter int OPERAND_ADDR_BITS = 3,
   parameter int BUFFER_NUM_WORDS  = 9,
   parameter int BUFFER_ADDR_BITS  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   output logic                         rdy,
   output logic [OPERAND_ADDR_BITS-1:0] a_addr,
   input  logic [31:0]                  a_din,
   output logic [OPERAND_ADDR_BITS-1:0] b_addr,
   input  logic [31:0]                  b_din,
   output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
   output logic                         s_wren,
   output logic [31:0]                  s_dout,
`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
   output logic                         zero,
`endif
   output logic                         neg
);

   // Cycle map: 0 idle, 1 first read issued, 2..N+1 word results, N+2 sign word.
   localparam int N        = OPERAND_NUM_WORDS;
   localparam int CNT_LAST = BUFFER_NUM_WORDS + 1;
   localparam int CNT_W    = $clog2(CNT_LAST + 1);

   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO       = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_READ_LAST = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_WORD_LAST = CNT_W'(N + 1);
   localparam logic [CNT_W-1:0] CNT_EXT       = CNT_W'(CNT_LAST);

   localparam logic [OPERAND_ADDR_BITS-1:0] ADDR_AB_LAST = OPERAND_ADDR_BITS'(N - 1);
   localparam logic [OPERAND_ADDR_BITS-1:0] ADDR_AB_ONE  = OPERAND_ADDR_BITS'(1);
   localparam logic [BUFFER_ADDR_BITS-1:0]  ADDR_S_ONE   = BUFFER_ADDR_BITS'(1);

   logic [CNT_W-1:0]             proc_cnt;
   logic [OPERAND_ADDR_BITS-1:0] addr_ab;
   logic [BUFFER_ADDR_BITS-1:0]  addr_s;
   logic                         brw;
   logic                         in_first;
   logic                         in_read;
   logic                         in_word;
   logic                         in_write;
   logic                         in_ext;
   logic [32:0]                  diff;

   // 33-bit subtract with incoming borrow; bit 32 is the outgoing borrow.
   function automatic logic [32:0] sub_with_borrow(input logic [31:0] x,
                                                   input logic [31:0] y,
                                                   input logic        b);
      sub_with_borrow = {1'b0, x} - {1'b0, y} - {32'd0, b};
   endfunction

   // Decode the phase of the operation from the cycle counter.
   always_comb begin
      in_first = (proc_cnt == CNT_ONE);
      in_read  = (proc_cnt >= CNT_ONE) && (proc_cnt <= CNT_READ_LAST);
      in_word  = (proc_cnt >= CNT_TWO) && (proc_cnt <= CNT_WORD_LAST);
      in_write = (proc_cnt >= CNT_TWO) && (proc_cnt <= CNT_EXT);
      in_ext   = (proc_cnt == CNT_EXT);
      diff     = sub_with_borrow(a_din, b_din, brw);
   end

   // Cycle counter: waits for ena when idle, free-runs and wraps when busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proc_cnt <= '0;
      end else if (rdy) begin
         if (ena) proc_cnt <= CNT_ONE;
      end else if (proc_cnt == CNT_EXT) begin
         proc_cnt <= '0;
      end else begin
         proc_cnt <= proc_cnt + CNT_ONE;
      end
   end

   assign rdy = (proc_cnt == '0);

   // Operand read address: steps through words during the read phase, else parked at 0.
   always_ff @(posedge clk) begin
      if (in_read) begin
         addr_ab <= (addr_ab == ADDR_AB_LAST) ? '0 : addr_ab + ADDR_AB_ONE;
      end else begin
         addr_ab <= '0;
      end
   end

   // Result write address: trails the read address by one cycle (memory latency).
   always_ff @(posedge clk) begin
      if (in_write) begin
         addr_s <= addr_s + ADDR_S_ONE;
      end else begin
         addr_s <= '0;
      end
   end

   // Borrow chain between words; cleared just before the first word arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brw <= 1'b0;
      end else if (in_first) begin
         brw <= 1'b0;
      end else if (in_word) begin
         brw <= diff[32];
      end
   end

   // Final borrow captured with the sign word; held until the next operation ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg <= 1'b0;
      end else if (in_ext) begin
         neg <= brw;
      end
   end

   // Write data: word difference, then the sign-extension word.
   always_comb begin
      s_dout = 32'd0;
      if (in_word) begin
         s_dout = diff[31:0];
      end else if (in_ext) begin
         s_dout = {32{brw}};
      end
   end

   assign s_wren = in_write;
   assign s_addr = addr_s;
   assign a_addr = addr_ab;
   assign b_addr = addr_ab;

`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
   logic zero_acc;

   // Running "all words zero so far" accumulator over the result words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_acc <= 1'b0;
      end else if (in_first) begin
         zero_acc <= 1'b1;
      end else if (in_word) begin
         zero_acc <= zero_acc & (s_dout == 32'd0);
      end
   end

   // Publish the equality flag alongside neg.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else if (in_ext) begin
         zero <= zero_acc;
      end
   end
`endif

endmodule

// File: tb/tb_modinv_helper_sub.sv
// Self-checking bench for modinv_helper_sub: directed and random operands
// compared against a 256-bit arithmetic reference of A - B.
module tb_modinv_helper_sub;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        rdy;
   logic [2:0]  a_addr;
   logic [31:0] a_din;
   logic [2:0]  b_addr;
   logic [31:0] b_din;
   logic [3:0]  s_addr;
   logic        s_wren;
   logic [31:0] s_dout;
   logic        neg;
`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
   logic        zero;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   modinv_helper_sub dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .rdy    (rdy),
      .a_addr (a_addr),
      .a_din  (a_din),
      .b_addr (b_addr),
      .b_din  (b_din),
      .s_addr (s_addr),
      .s_wren (s_wren),
      .s_dout (s_dout),
`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
      .zero   (zero),
`endif
      .neg    (neg)
   );

   // Operand memories with one-cycle registered read.
   logic [31:0] mem_a [N];
   logic [31:0] mem_b [N];
   always @(posedge clk) begin
      a_din <= mem_a[a_addr];
      b_din <= mem_b[b_addr];
   end

   // S buffer model plus per-address write counters, sampled mid-cycle.
   logic [31:0] s_mem [16];
   int          s_wcnt [16];
   int          wr_cnt = 0;
   initial for (int i = 0; i < 16; i++) begin s_mem[i] = 32'hDEADBEEF; s_wcnt[i] = 0; end
   always @(negedge clk) begin
      if (s_wren === 1'b1) begin
         s_mem[s_addr] = s_dout;
         s_wcnt[s_addr] = s_wcnt[s_addr] + 1;
         wr_cnt = wr_cnt + 1;
      end
   end

   // Reference: plain big-integer subtraction.
   function automatic logic [31:0] model_word(input logic [255:0] a, input logic [255:0] b,
                                              input int k);
      logic [256:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (k < N) return d[32*k +: 32];
      return (a < b) ? 32'hFFFFFFFF : 32'h0;
   endfunction

   logic exp_neg = 1'b0;
   int   base_w [16];
   int   base_total;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input logic [255:0] a, input logic [255:0] b);
      for (int k = 0; k < N; k++) begin
         mem_a[k] = a[32*k +: 32];
         mem_b[k] = b[32*k +: 32];
      end
   endtask

   task automatic snapshot();
      for (int i = 0; i < 16; i++) base_w[i] = s_wcnt[i];
      base_total = wr_cnt;
   endtask

   // Stimulus only: one operation from idle, returns cycles until rdy.
   task automatic run_op(input logic [255:0] a, input logic [255:0] b, output int cyc);
      load(a, b);
      snapshot();
      ena = 1'b1;
      step();
      ena = 1'b0;
      cyc = 1;
      while (rdy !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ena = 1'b0;
      step();
      checks++;
      if (rdy !== 1'b1 || s_wren !== 1'b0 || neg !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: rdy=%b s_wren=%b neg=%b required 1 0 0", rdy, s_wren, neg);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (rdy !== 1'b1 || s_wren !== 1'b0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL idle_%0d: rdy=%b s_wren=%b neg=%b required 1 0 0", i, rdy, s_wren, neg);
         end
`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
         checks++;
         if (zero !== 1'b0) begin
            errors++;
            $display("FAIL idle_zero_%0d: got %b required 0", i, zero);
         end
`endif
      end
   endtask

   task automatic test_directed();
      logic [255:0] va [3];
      logic [255:0] vb [3];
      int cyc;
      va[0] = 256'd5;           vb[0] = 256'd3;
      va[1] = 256'd0;           vb[1] = 256'd1;
      va[2] = 256'h1_0000_0000; vb[2] = 256'd1;
      for (int v = 0; v < 3; v++) begin
         load(va[v], vb[v]);
         snapshot();
         ena = 1'b1;
         step();
         ena = 1'b0;
         cyc = 1;
         while (rdy !== 1'b1 && cyc < 40) begin
            checks++;
            if (s_wren !== ((cyc >= 2 && cyc <= 10) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL dir%0d_wren_cnt%0d: got %b required %b", v, cyc, s_wren,
                        (cyc >= 2 && cyc <= 10));
            end
            step();
            cyc++;
         end
         exp_neg = (va[v] < vb[v]);
         checks++;
         if (cyc != 11) begin
            errors++;
            $display("FAIL dir%0d_latency: got %0d cycles required 11", v, cyc);
         end
         checks++;
         if (wr_cnt - base_total != 9) begin
            errors++;
            $display("FAIL dir%0d_writes: got %0d required 9", v, wr_cnt - base_total);
         end
         for (int k = 0; k <= N; k++) begin
            checks++;
            if (s_mem[k] !== model_word(va[v], vb[v], k) || s_wcnt[k] != base_w[k] + 1) begin
               errors++;
               $display("FAIL dir%0d_word%0d: got %h (%0d writes) required %h (1 write)", v, k,
                        s_mem[k], s_wcnt[k] - base_w[k], model_word(va[v], vb[v], k));
            end
         end
         checks++;
         if (neg !== exp_neg) begin
            errors++;
            $display("FAIL dir%0d_neg: got %b required %b", v, neg, exp_neg);
         end
      end
   endtask

   task automatic test_random();
      logic [255:0] a, b;
      int cyc;
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < N; k++) begin
            a[32*k +: 32] = $urandom;
            b[32*k +: 32] = $urandom;
         end
         if (t == 1) b = a;
         if (t == 2) b = a + 256'd1;
         run_op(a, b, cyc);
         exp_neg = (a < b);
         checks++;
         if (cyc != 11) begin
            errors++;
            $display("FAIL rnd%0d_latency: got %0d required 11", t, cyc);
         end
         for (int k = 0; k <= N; k++) begin
            checks++;
            if (s_mem[k] !== model_word(a, b, k)) begin
               errors++;
               $display("FAIL rnd%0d_word%0d: got %h required %h", t, k, s_mem[k],
                        model_word(a, b, k));
            end
         end
         checks++;
         if (neg !== exp_neg) begin
            errors++;
            $display("FAIL rnd%0d_neg: got %b required %b", t, neg, exp_neg);
         end
`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
         checks++;
         if (zero !== (a == b)) begin
            errors++;
            $display("FAIL rnd%0d_zero: got %b required %b", t, zero, (a == b));
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] a1, b1, a2, b2;
      logic old_neg, n1, n2, exp_n, exp_r;
      a1 = 256'd0; b1 = 256'd1;
      a2 = 256'd5; b2 = 256'd3;
      old_neg = exp_neg;
      n1 = (a1 < b1);
      n2 = (a2 < b2);
      load(a1, b1);
      snapshot();
      ena = 1'b1;
      step();
      for (int idx = 1; idx <= 22; idx++) begin
         exp_r = ((idx % 11) == 0);
         exp_n = (idx <= 10) ? old_neg : ((idx <= 21) ? n1 : n2);
         checks++;
         if (rdy !== exp_r || neg !== exp_n) begin
            errors++;
            $display("FAIL b2b_cyc%0d: rdy=%b neg=%b required rdy=%b neg=%b", idx, rdy, neg,
                     exp_r, exp_n);
         end
         if (idx == 10) load(a2, b2);
         if (idx == 11) begin
            for (int k = 0; k <= N; k++) begin
               checks++;
               if (s_mem[k] !== model_word(a1, b1, k)) begin
                  errors++;
                  $display("FAIL b2b_op1_word%0d: got %h required %h", k, s_mem[k],
                           model_word(a1, b1, k));
               end
            end
         end
         if (idx >= 12 && idx <= 20) ena = $urandom_range(0, 1);
         if (idx == 21) ena = 1'b0;
         if (idx < 22) step();
      end
      exp_neg = n2;
      checks++;
      if (wr_cnt - base_total != 18) begin
         errors++;
         $display("FAIL b2b_writes: got %0d required 18", wr_cnt - base_total);
      end
      for (int k = 0; k <= N; k++) begin
         checks++;
         if (s_mem[k] !== model_word(a2, b2, k)) begin
            errors++;
            $display("FAIL b2b_op2_word%0d: got %h required %h", k, s_mem[k],
                     model_word(a2, b2, k));
         end
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      run_op(256'd0, 256'd1, cyc);
      exp_neg = 1'b1;
      checks++;
      if (neg !== exp_neg) begin
         errors++;
         $display("FAIL mid_pre_neg: got %b required %b", neg, exp_neg);
      end
      load(256'd7, 256'd9);
      ena = 1'b1;
      step();
      ena = 1'b0;
      repeat (4) step();
      checks++;
      if (s_wren !== 1'b1 || rdy !== 1'b0) begin
         errors++;
         $display("FAIL mid_busy_cnt5: s_wren=%b rdy=%b required 1 0", s_wren, rdy);
      end
      rst_n = 1'b0;
      #1;
      exp_neg = 1'b0;
      checks++;
      if (s_wren !== 1'b0 || rdy !== 1'b1 || neg !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: s_wren=%b rdy=%b neg=%b required 0 1 0", s_wren, rdy, neg);
      end
      step();
      checks++;
      if (a_addr !== 3'd0 || b_addr !== 3'd0 || s_addr !== 4'd0) begin
         errors++;
         $display("FAIL mid_addr: a=%0d b=%0d s=%0d required 0 0 0", a_addr, b_addr, s_addr);
      end
      rst_n = 1'b1;
      step();
   endtask

`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
   task automatic test_zero();
      int cyc;
      run_op(256'h1234, 256'h1234, cyc);
      checks++;
      if (zero !== 1'b1 || neg !== 1'b0) begin
         errors++;
         $display("FAIL zero_equal: zero=%b neg=%b required 1 0", zero, neg);
      end
      run_op(256'h1234, 256'h1235, cyc);
      checks++;
      if (zero !== 1'b0 || neg !== 1'b1) begin
         errors++;
         $display("FAIL zero_diff: zero=%b neg=%b required 0 1", zero, neg);
      end
      exp_neg = 1'b1;
   endtask
`endif

   initial begin
      for (int k = 0; k < N; k++) begin mem_a[k] = 32'd0; mem_b[k] = 32'd0; end
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef MODINV_HELPER_SUB_ZERO_FLAG_EN
      test_zero();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/modinv_helper_sub.md
Name: modinv_helper_sub

Overview:
- Multi-word subtractor helper for the modular invertor datapath; computes S = A - B over OPERAND_NUM_WORDS 32-bit words, least significant word first.
- Reads two operand memories and writes the result plus a sign-extension word into the BUFFER_NUM_WORDS-deep S buffer.
- Sits directly upstream of the S-to-A1 copy helper, which consumes the low OPERAND_NUM_WORDS words of S.
- Also reports the sign of the difference so the invertor FSM can select the next branch.

Parameters:
- OPERAND_NUM_WORDS, 8, number of 32-bit words per operand.
- OPERAND_ADDR_BITS, 3, address width of the A and B operand memories.
- BUFFER_NUM_WORDS, 9, S buffer depth; must equal OPERAND_NUM_WORDS + 1.
- BUFFER_ADDR_BITS, 4, address width of the S buffer; must be >= OPERAND_ADDR_BITS + 1.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, start pulse; sampled only while rdy = 1.
- rdy, output, 1, idle / done flag.
- a_addr, output, OPERAND_ADDR_BITS, A memory read address.
- a_din, input, 32, A read data; 1-cycle registered read latency.
- b_addr, output, OPERAND_ADDR_BITS, B memory read address; always equals a_addr.
- b_din, input, 32, B read data; 1-cycle latency.
- s_addr, output, BUFFER_ADDR_BITS, S buffer write address.
- s_wren, output, 1, S buffer write enable.
- s_dout, output, 32, S buffer write data.
- neg, output, 1, registered final borrow (1 = A < B); valid when rdy = 1.

Behaviour:
- Counter proc_cnt, 0 .. N+2, where N = OPERAND_NUM_WORDS and PROC_NUM_CYCLES = N + 3.
  - Asynchronous reset to 0.
  - While rdy = 1: increments only when ena = 1.
  - While rdy = 0: increments every cycle and wraps N+2 -> 0.
- rdy = (proc_cnt == 0). ena while busy is ignored.
- Read address addr_ab:
  - Synchronous, no reset; held at 0 when not incrementing.
  - Increments at proc_cnt 1..N; wraps at N-1 -> 0.
  - Result: word k is presented at cnt k+1 and its data is valid at cnt k+2.
- Write address addr_s:
  - Increments at proc_cnt 2..N+2, otherwise forced to 0.
  - Word k is written at cnt k+2, k = 0..N.
  - s_addr = addr_s, zero-extended to BUFFER_ADDR_BITS.
- s_wren = 1 for proc_cnt 2..N+2 inclusive (N+1 writes), 0 otherwise. Reset value 0, since proc_cnt = 0 at reset.
- Borrow register brw:
  - Async reset 0; cleared at proc_cnt 1.
  - At cnt 2..N+1 loads the carry-out of the 33-bit subtraction.
- s_dout:
  - cnt 2..N+1: (a_din - b_din - brw)[31:0].
  - cnt N+2: {32{brw}} (sign extension).
  - Otherwise 0.
- neg: async reset 0; loads brw at cnt N+2 and holds until the next operation's cnt N+2.
- Equal operands: all result words 0, extension 0, neg = 0.
- Back-to-back operation: ena asserted in the cycle rdy returns high starts the next operation immediately.
- Reset mid-operation:
  - proc_cnt, brw and neg go to 0 asynchronously; s_wren drops to 0 at once.
  - Addresses settle to 0 on the next clock.
  - Partial S contents are undefined.

Optional Feature:
- Macro: MODINV_HELPER_SUB_ZERO_FLAG_EN.
- With the macro: output port zero (1 bit) is added.
  - Internal accumulator is set at cnt 1.
  - Accumulator is ANDed with (s_dout == 0) at cnt 2..N+1.
  - zero is registered at cnt N+2; async reset 0; valid when rdy = 1.
  - zero = 1 iff A == B.
- Without the macro: port and logic are absent.

Test Plan (N = 8):
- Reset, then idle 5 cycles:
  - Required: rdy = 1, s_wren = 0, neg = 0 throughout.
  - Required: no proc_cnt advance without ena.
- A = 5 (word0 = 5, rest 0), B = 3:
  - Required: S = {2, 0 x7, ext 0}, neg = 0.
  - Required: exactly 9 writes at cnt 2..10; rdy high again at cnt 0, i.e. 11 cycles after ena.
- A = 0, B = 1:
  - Required: S words 0..7 = 0xFFFFFFFF, ext = 0xFFFFFFFF, neg = 1.
- Borrow chain, A = 2^32 (word1 = 1, word0 = 0), B = 1:
  - Required: word0 = 0xFFFFFFFF, word1 = 0, ext 0, neg = 0.
- Back-to-back: ena held high across two operations:
  - Required: second operation starts in the cycle rdy rises.
  - Required: ena pulses while busy have no effect.
  - Required: neg updates only at cnt 10.
- Reset and zero flag:
  - rst_n asserted at cnt 5 -> s_wren = 0 and rdy = 1 immediately.
  - A = B = 0x1234 (macro on) -> zero = 1, neg = 0.
  - A = 0x1234, B = 0x1235 -> zero = 0.
